feature_mem_loader: RTL and testbench
=====================================

FEATURE_MEM_LOADER -- requirements
Module: feature_mem_loader

Interface
REQ-001 SHALL have parameter Tn, default 4, number of feature memory groups (1..16).
REQ-002 SHALL have parameter KERNEL_SIZE, default 5, number of lines per group (1..16).
REQ-003 SHALL have parameter DATA_BUS_WIDTH, default 64, width of one input word.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a load; honoured only in IDLE.
REQ-007 SHALL have port line_mode  input  1  sampled at start: 0 = full load, 1 = single-line refill.
REQ-008 SHALL have port refill_line  input  4  sampled at start: target line for a refill.
REQ-009 SHALL have port kn_size_mode  input  2  sampled at start: selects the active line count.
REQ-010 SHALL have port abort  input  1  terminates the load in progress.
REQ-011 SHALL have port in_valid  input  1  input word valid.
REQ-012 SHALL have port in_ready  output  1  loader accepts a word.
REQ-013 SHALL have port in_data  input  DATA_BUS_WIDTH  input feature word.
REQ-014 SHALL have port wr_en  output  1  write strobe to the feature memory.
REQ-015 SHALL have port wr_mem_group  output  4  destination group.
REQ-016 SHALL have port wr_mem_line  output  4  destination line.
REQ-017 SHALL have port wr_data  output  DATA_BUS_WIDTH  write data.
REQ-018 SHALL have port busy  output  1  high while in LOAD or DONE.
REQ-019 SHALL have port done  output  1  one-cycle pulse when a load completes.

Function
REQ-020 SHALL implement the states IDLE, LOAD and DONE.
REQ-021 IDLE->LOAD on start=1; latch line_mode, refill_line and kn_size_mode; clear the group and line counters; apply line-count rule (REQ-022).
REQ-022 Active line count L SHALL be 1/3/5/KERNEL_SIZE for kn_size_mode 0/1/2/3, clipped to KERNEL_SIZE.
REQ-023 in_ready SHALL be 1 exactly when the state is LOAD; a word is accepted when in_valid and in_ready are both 1.
REQ-024 Full load: accepted words SHALL map group-major: group 0 lines 0..L-1, then group 1, ..., up to group Tn-1; total Tn*L words.
REQ-025 Refill: accepted words SHALL map to groups 0..Tn-1 in order, each at line refill_line; total Tn words.
REQ-026 Refill with refill_line>=L SHALL be treated as line L-1.
REQ-027 For each accepted word, wr_en, wr_mem_group, wr_mem_line and wr_data SHALL be registered and valid exactly 1 cycle after acceptance; wr_en SHALL be 0 otherwise.
REQ-028 When wr_en=0, wr_data, wr_mem_group and wr_mem_line SHALL be 0.
REQ-029 in_valid=0 cycles SHALL stall the counters without any write.
REQ-030 On acceptance of the last word: LOAD->DONE, and in_ready SHALL drop to 0 in the next cycle.
REQ-031 In DONE, done SHALL be 1 for one cycle, coincident with the last wr_en, then the state SHALL return to IDLE.
REQ-032 start in LOAD or DONE SHALL be ignored.
REQ-033 abort=1 in LOAD SHALL return the state to IDLE next cycle with no done pulse; a word accepted in the same cycle SHALL still be written.
REQ-034 abort=1 in IDLE or DONE SHALL have no effect.
REQ-035 start and abort both 1 in IDLE SHALL start a load.
REQ-036 Counter wrap: after line L-1 the line counter SHALL wrap to 0 and the group counter SHALL increment; neither SHALL exceed Tn-1 or L-1.

Reset
REQ-037 rst=1 SHALL force IDLE and clear all counters and latched configuration.
REQ-038 During rst=1, in_ready, wr_en, wr_mem_group, wr_mem_line, wr_data, busy and done SHALL all be 0.
REQ-039 rst asserted mid-load SHALL discard the load: no further writes and no done pulse.

Verification
REQ-040 Setup: Tn=4, KERNEL_SIZE=5, kn_size_mode=1, full load, in_valid always 1; required: 12 writes in the order (g,l) = (0,0),(0,1),(0,2),(1,0),...,(3,2), the data matches the inputs, and done coincides with the 12th write.
REQ-041 Setup: as REQ-040, with in_valid toggling every other cycle; required: the same 12 writes in the same order, each 1 cycle after acceptance, with no writes during stalls.
REQ-042 Setup: refill with refill_line=2, kn_size_mode=2; required: 4 writes (0,2),(1,2),(2,2),(3,2), then done. Setup: refill_line=7, kn_size_mode=1; required: the writes go to line 2.
REQ-043 Setup: abort after the 5th accepted word; required: exactly 5 writes, no done, busy=0 two cycles later, and a new start is accepted.
REQ-044 Setup: rst after the 3rd accepted word; required: all outputs 0 from the next cycle and no done. Setup: start pulsed during LOAD; required: the start is ignored and the word count is unchanged.

Source files
------------

// File: rtl/feature_mem_loader.sv
// Streams input words into a Tn x KERNEL_SIZE feature memory, either as a full
// group-major load or as a single-line refill across all groups.
module feature_mem_loader #(
    parameter int Tn             = 4,
    parameter int KERNEL_SIZE    = 5,
    parameter int DATA_BUS_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      line_mode,
    input  logic [3:0]                refill_line,
    input  logic [1:0]                kn_size_mode,
    input  logic                      abort,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_BUS_WIDTH-1:0] in_data,
    output logic                      wr_en,
    output logic [3:0]                wr_mem_group,
    output logic [3:0]                wr_mem_line,
    output logic [DATA_BUS_WIDTH-1:0] wr_data,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [3:0] GRP_LAST = 4'(Tn - 1);
    localparam logic [4:0] KS       = 5'(KERNEL_SIZE);

    state_t     state;
    logic       mode;
    logic [3:0] line_last;
    logic [3:0] refill_tgt;
    logic [3:0] grp_cnt;
    logic [3:0] line_cnt;
    logic       accept;
    logic       is_last;
    logic [3:0] cur_line;

    logic                      wr_en_p0;
    logic [3:0]                wr_group_p0;
    logic [3:0]                wr_line_p0;
    logic [DATA_BUS_WIDTH-1:0] wr_data_p0;

    // Index of the last active line for a kernel-size mode, clipped to the memory depth.
    function automatic logic [3:0] calc_line_last(input logic [1:0] m);
        logic [4:0] n;
        case (m)
            2'd0:    n = 5'd1;
            2'd1:    n = 5'd3;
            2'd2:    n = 5'd5;
            default: n = KS;
        endcase
        if (n > KS) n = KS;
        return 4'(n - 5'd1);
    endfunction

    function automatic logic [3:0] clip_line(input logic [3:0] req, input logic [3:0] last);
        return (req > last) ? last : req;
    endfunction

    assign accept   = in_valid && in_ready;
    assign cur_line = mode ? refill_tgt : line_cnt;
    assign is_last  = (grp_cnt == GRP_LAST) && (mode || (line_cnt == line_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode       <= 1'b0;
            line_last  <= '0;
            refill_tgt <= '0;
            grp_cnt    <= '0;
            line_cnt   <= '0;
            wr_en_p0   <= 1'b0;
        end else begin
            wr_en_p0 <= accept;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        mode       <= line_mode;
                        line_last  <= calc_line_last(kn_size_mode);
                        refill_tgt <= clip_line(refill_line, calc_line_last(kn_size_mode));
                        grp_cnt    <= '0;
                        line_cnt   <= '0;
                    end
                end
                LOAD: begin
                    // The final word leaves the counters parked at their last position.
                    if (accept && !is_last) begin
                        if (mode || line_cnt == line_last) begin
                            line_cnt <= '0;
                            grp_cnt  <= grp_cnt + 4'd1;
                        end else begin
                            line_cnt <= line_cnt + 4'd1;
                        end
                    end
                    if (abort)                  state <= IDLE;
                    else if (accept && is_last) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p0: write port registers, zeroed whenever no word was accepted.
    always_ff @(posedge clk) begin
        wr_data_p0  <= accept ? in_data : '0;
        wr_group_p0 <= accept ? grp_cnt : '0;
        wr_line_p0  <= accept ? cur_line : '0;
    end

    // Outputs are held at zero for every cycle reset is asserted.
    assign in_ready     = (state == LOAD) && !rst;
    assign busy         = (state != IDLE) && !rst;
    assign done         = (state == DONE) && !rst;
    assign wr_en        = wr_en_p0 && !rst;
    assign wr_mem_group = rst ? '0 : wr_group_p0;
    assign wr_mem_line  = rst ? '0 : wr_line_p0;
    assign wr_data      = rst ? '0 : wr_data_p0;

endmodule

// File: tb/tb_feature_mem_loader.sv
// Directed and randomized checks of feature_mem_loader against a write-plan
// reference model built from the addressing rules.
module tb_feature_mem_loader;

    localparam int TN = 4;
    localparam int KS = 5;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          line_mode = 1'b0;
    logic [3:0]    refill_line = '0;
    logic [1:0]    kn_size_mode = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          wr_en;
    logic [3:0]    wr_mem_group;
    logic [3:0]    wr_mem_line;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;

    feature_mem_loader #(.Tn(TN), .KERNEL_SIZE(KS), .DATA_BUS_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .line_mode(line_mode),
        .refill_line(refill_line), .kn_size_mode(kn_size_mode), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_en(wr_en), .wr_mem_group(wr_mem_group), .wr_mem_line(wr_mem_line),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: the list of (group, line) destinations for the current load.
    bit m_load = 0;
    bit m_done = 0;
    int plan_g[$];
    int plan_l[$];
    int idx = 0;
    int n_wr = 0;
    int n_done = 0;
    int last_line = 0;

    function automatic int active_lines(input int m);
        int t[4];
        int v;
        t = '{1, 3, 5, KS};
        v = t[m];
        return (v > KS) ? KS : v;
    endfunction

    task automatic build_plan();
        int nl;
        int tl;
        nl = active_lines(int'(kn_size_mode));
        plan_g.delete();
        plan_l.delete();
        if (line_mode) begin
            tl = (int'(refill_line) >= nl) ? nl - 1 : int'(refill_line);
            for (int g = 0; g < TN; g++) begin
                plan_g.push_back(g);
                plan_l.push_back(tl);
            end
        end else begin
            for (int g = 0; g < TN; g++)
                for (int l = 0; l < nl; l++) begin
                    plan_g.push_back(g);
                    plan_l.push_back(l);
                end
        end
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [79:0] dut_vec();
        return {in_ready, busy, done, wr_en, wr_mem_group, wr_mem_line, wr_data};
    endfunction

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic cycle(input string tag, input logic v, input logic s, input logic a);
        logic          acc;
        logic [DW-1:0] d;
        int            eg;
        int            el;
        d = {$urandom, $urandom};
        in_valid = v;
        start    = s;
        abort    = a;
        in_data  = d;
        acc = m_load && v;
        eg = acc ? plan_g[idx] : 0;
        el = acc ? plan_l[idx] : 0;
        if (acc) idx++;
        if (m_load) begin
            if (a) m_load = 0;
            else if (acc && idx == plan_g.size()) begin
                m_load = 0;
                m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (s) begin
            build_plan();
            idx    = 0;
            m_load = 1;
        end
        @(posedge clk);
        #1;
        check(tag, dut_vec(), {m_load, m_load || m_done, m_done, acc, 4'(eg), 4'(el), acc ? d : '0});
        if (wr_en) begin
            n_wr++;
            last_line = int'(wr_mem_line);
        end
        if (done) n_done++;
        in_valid = 0;
        start    = 0;
        abort    = 0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1;
        #1;
        check({tag, "_during"}, dut_vec(), '0);
        @(posedge clk);
        #1;
        check({tag, "_after"}, dut_vec(), '0);
        rst    = 0;
        m_load = 0;
        m_done = 0;
    endtask

    task automatic configure(input logic lm, input logic [3:0] rl, input logic [1:0] km);
        line_mode    = lm;
        refill_line  = rl;
        kn_size_mode = km;
        n_wr         = 0;
        n_done       = 0;
    endtask

    task automatic drain(input string tag, input int pct);
        for (int k = 0; k < 300 && (m_load || m_done); k++)
            cycle(tag, ($urandom_range(99) < pct), 1'b0, 1'b0);
        check({tag, "_bound"}, 80'(m_load || m_done), 80'(0));
    endtask

    initial begin
        do_reset("reset");

        // Full load, three active lines, continuous input.
        configure(1'b0, 4'd0, 2'd1);
        cycle("s40_start", 1'b0, 1'b1, 1'b0);
        drain("s40", 100);
        check("s40_writes", 80'(n_wr), 80'(12));
        check("s40_done", 80'(n_done), 80'(1));

        // Same load with in_valid toggling.
        configure(1'b0, 4'd0, 2'd1);
        cycle("s41_start", 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 60 && (m_load || m_done); k++)
            cycle("s41", (k % 2 == 0), 1'b0, 1'b0);
        check("s41_writes", 80'(n_wr), 80'(12));
        check("s41_done", 80'(n_done), 80'(1));

        // Refill of line 2, then an out-of-range refill line.
        configure(1'b1, 4'd2, 2'd2);
        cycle("s42a_start", 1'b0, 1'b1, 1'b0);
        drain("s42a", 100);
        check("s42a_writes", 80'(n_wr), 80'(4));
        check("s42a_line", 80'(last_line), 80'(2));
        configure(1'b1, 4'd7, 2'd1);
        cycle("s42b_start", 1'b0, 1'b1, 1'b0);
        drain("s42b", 100);
        check("s42b_writes", 80'(n_wr), 80'(4));
        check("s42b_line", 80'(last_line), 80'(2));

        // Abort after five accepted words, then restart with start and abort together.
        configure(1'b0, 4'd0, 2'd2);
        cycle("s43_start", 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle("s43_load", 1'b1, 1'b0, 1'b0);
        cycle("s43_abort", 1'b0, 1'b0, 1'b1);
        cycle("s43_idle", 1'b0, 1'b0, 1'b1);
        cycle("s43_idle", 1'b0, 1'b0, 1'b0);
        check("s43_writes", 80'(n_wr), 80'(5));
        check("s43_done", 80'(n_done), 80'(0));
        configure(1'b0, 4'd0, 2'd0);
        cycle("s43_restart", 1'b0, 1'b1, 1'b1);
        drain("s43_re", 100);
        check("s43_re_writes", 80'(n_wr), 80'(4));

        // Reset after the third accepted word.
        configure(1'b0, 4'd0, 2'd3);
        cycle("s44a_start", 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle("s44a_load", 1'b1, 1'b0, 1'b0);
        do_reset("s44a_rst");
        cycle("s44a_post", 1'b1, 1'b0, 1'b0);
        cycle("s44a_post", 1'b1, 1'b0, 1'b0);
        check("s44a_writes", 80'(n_wr), 80'(3));
        check("s44a_done", 80'(n_done), 80'(0));

        // Start pulses during a load are ignored.
        configure(1'b0, 4'd0, 2'd1);
        cycle("s44b_start", 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 60 && (m_load || m_done); k++)
            cycle("s44b", 1'b1, (k % 3 == 1), 1'b0);
        check("s44b_writes", 80'(n_wr), 80'(12));
        check("s44b_done", 80'(n_done), 80'(1));

        // Randomized configurations, stalls, stray starts and occasional aborts.
        for (int t = 0; t < 40; t++) begin
            configure(1'($urandom_range(1)), 4'($urandom_range(15)), 2'($urandom_range(3)));
            cycle("rnd_start", 1'($urandom_range(1)), 1'b1, 1'($urandom_range(1)));
            for (int k = 0; k < 300 && (m_load || m_done); k++)
                cycle("rnd", ($urandom_range(99) < 70), ($urandom_range(9) == 0),
                      ($urandom_range(59) == 0));
            cycle("rnd_idle", 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
